// File: rtl/cxu_mac_seq.sv
// Iterative radix-2^BPC multiply / multiply-accumulate custom-instruction unit
// with per-context accumulators, high-half product and unsigned multiply.
module cxu_mac_seq #(
    parameter int XLEN       = 32,
    parameter int NUM_STATES = 8,
    parameter int BPC        = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_payload_function_id,
    input  logic [XLEN-1:0] cmd_payload_inputs_0,
    input  logic [XLEN-1:0] cmd_payload_inputs_1,
    input  logic [2:0]      cmd_payload_state_id,
    input  logic [3:0]      cmd_payload_cxu_id,
    input  logic            cmd_payload_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_payload_outputs_0,
    output logic            rsp_payload_ready
);

    localparam int ITER  = XLEN / BPC;
    localparam int PW    = 2 * XLEN;
    localparam int CTX_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
    localparam int CNT_W = $clog2(ITER + 1);

    localparam logic [2:0] FN_MUL    = 3'd0;
    localparam logic [2:0] FN_MULH   = 3'd1;
    localparam logic [2:0] FN_MAC    = 3'd2;
    localparam logic [2:0] FN_ACCRD  = 3'd3;
    localparam logic [2:0] FN_ACCCLR = 3'd4;
    localparam logic [2:0] FN_MULU   = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Magnitude needs XLEN+1 bits so that -2^(XLEN-1) is representable.
    function automatic logic [XLEN:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        logic [XLEN:0] m;
        if (is_signed && v[XLEN-1]) begin
            m = -{1'b1, v};
        end else begin
            m = {1'b0, v};
        end
        return m;
    endfunction

    function automatic logic is_mul_op(input logic [2:0] fn);
        logic r;
        case (fn)
            FN_MUL, FN_MULH, FN_MAC, FN_MULU: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    state_t            state_r, state_next;
    logic [2:0]        fn_r;
    logic [CTX_W-1:0]  ctx_r;
    logic [PW-1:0]     mcand_r;
    logic [XLEN:0]     mplier_r;
    logic [PW-1:0]     prod_r;
    logic              neg_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   acc_r [NUM_STATES];
    logic [XLEN-1:0]   rsp_out_r;
    logic              rsp_valid_r;
    logic              cmd_ready_r;

    logic              accept_s;
    logic              last_s;
    logic              in_signed_s;
    logic [CTX_W-1:0]  in_ctx_s;
    logic [XLEN:0]     a_mag_s;
    logic [XLEN:0]     b_mag_s;
    logic [PW-1:0]     partial_s;
    logic [PW-1:0]     prod_sum_s;
    logic [PW-1:0]     prod_final_s;
    logic [XLEN-1:0]   mul_res_s;
    logic [XLEN-1:0]   mac_sum_s;
    logic [XLEN-1:0]   imm_res_s;
    logic              unused_s;

    assign unused_s = ^{cmd_payload_cxu_id, cmd_payload_ready, cmd_payload_state_id};

    assign accept_s    = cmd_valid && cmd_ready_r;
    assign in_signed_s = (cmd_payload_function_id != FN_MULU);
    assign in_ctx_s    = cmd_payload_state_id[CTX_W-1:0];
    assign a_mag_s     = magnitude(cmd_payload_inputs_0, in_signed_s);
    assign b_mag_s     = magnitude(cmd_payload_inputs_1, in_signed_s);
    assign last_s      = (cnt_r == CNT_W'(ITER - 1));

    // One radix-2^BPC step plus final sign fix-up and result selection.
    always_comb begin
        partial_s    = mcand_r * PW'(mplier_r[BPC-1:0]);
        prod_sum_s   = prod_r + partial_s;
        prod_final_s = neg_r ? -prod_sum_s : prod_sum_s;
        mac_sum_s    = acc_r[ctx_r] + prod_final_s[XLEN-1:0];
        case (fn_r)
            FN_MULH: mul_res_s = prod_final_s[PW-1:XLEN];
            FN_MAC:  mul_res_s = mac_sum_s;
            default: mul_res_s = prod_final_s[XLEN-1:0];
        endcase
        case (cmd_payload_function_id)
            FN_ACCRD, FN_ACCCLR: imm_res_s = acc_r[in_ctx_s];
            default:             imm_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = is_mul_op(cmd_payload_function_id) ? BUSY : RESP;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_next = RESP;
                end else begin
                    state_next = BUSY;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next;
            cmd_ready_r <= (state_next == IDLE);
            rsp_valid_r <= (state_next == RESP);
        end
    end

    // Operand capture and iterative multiply datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            fn_r      <= 3'd0;
            ctx_r     <= {CTX_W{1'b0}};
            mcand_r   <= {PW{1'b0}};
            mplier_r  <= {(XLEN+1){1'b0}};
            prod_r    <= {PW{1'b0}};
            neg_r     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            rsp_out_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        fn_r     <= cmd_payload_function_id;
                        ctx_r    <= in_ctx_s;
                        mcand_r  <= {{(PW-XLEN-1){1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        prod_r   <= {PW{1'b0}};
                        neg_r    <= in_signed_s &&
                                    (cmd_payload_inputs_0[XLEN-1] ^ cmd_payload_inputs_1[XLEN-1]);
                        cnt_r    <= {CNT_W{1'b0}};
                        if (!is_mul_op(cmd_payload_function_id)) begin
                            rsp_out_r <= imm_res_s;
                        end else begin
                            rsp_out_r <= rsp_out_r;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                BUSY: begin
                    prod_r   <= prod_sum_s;
                    mcand_r  <= mcand_r << BPC;
                    mplier_r <= mplier_r >> BPC;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        rsp_out_r <= mul_res_s;
                    end else begin
                        rsp_out_r <= rsp_out_r;
                    end
                end
                default: begin
                    rsp_out_r <= rsp_out_r;
                end
            endcase
        end
    end

    // Accumulator contexts: MAC commits on the BUSY->RESP edge, ACCCLR on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                acc_r[i] <= {XLEN{1'b0}};
            end
        end else if (state_r == BUSY && last_s && fn_r == FN_MAC) begin
            acc_r[ctx_r] <= mac_sum_s;
        end else if (accept_s && cmd_payload_function_id == FN_ACCCLR) begin
            acc_r[in_ctx_s] <= {XLEN{1'b0}};
        end else begin
            acc_r[0] <= acc_r[0];
        end
    end

    assign cmd_ready             = cmd_ready_r;
    assign rsp_valid             = rsp_valid_r;
    assign rsp_payload_outputs_0 = rsp_out_r;
    assign rsp_payload_ready     = rsp_valid_r;

endmodule

// File: tb/tb_cxu_mac_seq.sv
// Directed, table-driven bench for cxu_mac_seq; a second instance with
// NUM_STATES=2 shares the command stream to observe context aliasing.
module tb_cxu_mac_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  fn;
    logic [31:0] in0, in1;
    logic [2:0]  sid;
    logic        rsp_ready;

    logic        cmd_ready, rsp_valid, prdy;
    logic [31:0] out;
    logic        cmd_ready2, rsp_valid2, prdy2;
    logic [31:0] out2;

    int total = 0;
    int passed = 0;
    logic [31:0] r2_out;
    logic        r2_valid;

    always #5 clk = ~clk;

    cxu_mac_seq #(.XLEN(32), .NUM_STATES(8), .BPC(4)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(fn), .cmd_payload_inputs_0(in0),
        .cmd_payload_inputs_1(in1), .cmd_payload_state_id(sid),
        .cmd_payload_cxu_id(4'd0), .cmd_payload_ready(1'b0),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(out), .rsp_payload_ready(prdy)
    );

    cxu_mac_seq #(.XLEN(32), .NUM_STATES(2), .BPC(4)) u_dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_payload_function_id(fn), .cmd_payload_inputs_0(in0),
        .cmd_payload_inputs_1(in1), .cmd_payload_state_id(sid),
        .cmd_payload_cxu_id(4'd0), .cmd_payload_ready(1'b0),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(out2), .rsp_payload_ready(prdy2)
    );

    typedef struct {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sid;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Issue one command, wait for the response, optionally stall, then handshake.
    task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] s,
                       input logic [31:0] exp, input int exp_lat, input int hold);
        int   lat;
        bit   got;
        bit   busy_ready;
        @(negedge clk);
        check({name, " ready_before"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; fn = f; in0 = a; in1 = b; sid = s;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0; got = 1'b0; busy_ready = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (cmd_ready) busy_ready = 1'b1;
            if (rsp_valid) got = 1'b1;
        end
        check({name, " rsp_seen"}, {31'd0, got}, 32'd1);
        check({name, " latency"}, lat, exp_lat);
        check({name, " out"}, out, exp);
        check({name, " cmd_ready_low"}, {31'd0, busy_ready}, 32'd0);
        check({name, " rsp_payload_ready"}, {31'd0, prdy}, 32'd1);
        r2_out = out2;
        r2_valid = rsp_valid2;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({name, " hold_out"}, out, exp);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({name, " idle_after"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    vec_t vecs [18];

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        3'd0, 32'hFFFFFFEB, 9};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 3'd0, 32'h40000000, 9};
        vecs[2]  = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 32'h00000001, 9};
        vecs[3]  = '{3'd0, 32'h7FFFFFFF, 32'd2,        3'd0, 32'hFFFFFFFE, 9};
        vecs[4]  = '{3'd1, 32'hFFFFFFFF, 32'd1,        3'd0, 32'hFFFFFFFF, 9};
        vecs[5]  = '{3'd1, 32'h00010000, 32'h00010000, 3'd0, 32'h00000001, 9};
        vecs[6]  = '{3'd5, 32'h80000000, 32'd2,        3'd0, 32'h00000000, 9};
        vecs[7]  = '{3'd2, 32'd3,        32'd4,        3'd2, 32'd12,       9};
        vecs[8]  = '{3'd2, 32'd5,        32'd6,        3'd2, 32'd42,       9};
        vecs[9]  = '{3'd3, 32'd0,        32'd0,        3'd3, 32'd0,        1};
        vecs[10] = '{3'd3, 32'd0,        32'd0,        3'd2, 32'd42,       1};
        vecs[11] = '{3'd4, 32'd0,        32'd0,        3'd2, 32'd42,       1};
        vecs[12] = '{3'd3, 32'd0,        32'd0,        3'd2, 32'd0,        1};
        vecs[13] = '{3'd2, 32'hFFFFFFFE, 32'd3,        3'd5, 32'hFFFFFFFA, 9};
        vecs[14] = '{3'd2, 32'd2,        32'd3,        3'd5, 32'd0,        9};
        vecs[15] = '{3'd6, 32'd9,        32'd9,        3'd1, 32'd0,        1};
        vecs[16] = '{3'd7, 32'd9,        32'd9,        3'd1, 32'd0,        1};
        vecs[17] = '{3'd2, 32'd7,        32'd7,        3'd1, 32'd49,       9};

        reset = 1'b1; cmd_valid = 1'b0; fn = 3'd0; in0 = 32'd0; in1 = 32'd0;
        sid = 3'd0; rsp_ready = 1'b0; r2_out = 32'd0; r2_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset out", out, 32'd0);
        check("reset rsp_payload_ready", {31'd0, prdy}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            run($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].sid,
                vecs[i].exp, vecs[i].lat, 0);
        end

        // Response held stable while rsp_ready stays low.
        run("hold", 3'd0, 32'd6, 32'd7, 3'd0, 32'd42, 9, 5);

        // Reset in BUSY cycle 4 aborts the op and clears every accumulator.
        @(negedge clk);
        cmd_valid = 1'b1; fn = 3'd0; in0 = 32'd5; in1 = 32'd5; sid = 3'd0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midreset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (10) @(negedge clk);
        check("midreset no_rsp", {31'd0, rsp_valid}, 32'd0);
        run("midreset acc1", 3'd3, 32'd0, 32'd0, 3'd1, 32'd0, 1, 0);
        run("midreset acc5", 3'd3, 32'd0, 32'd0, 3'd5, 32'd0, 1, 0);

        // state_id 2 aliases context 0 on the two-context instance.
        run("alias mac", 3'd2, 32'd3, 32'd4, 3'd0, 32'd12, 9, 0);
        run("alias rd", 3'd3, 32'd0, 32'd0, 3'd2, 32'd0, 1, 0);
        check("alias dut2 valid", {31'd0, r2_valid}, 32'd1);
        check("alias dut2 out", r2_out, 32'd12);
        check("dut2 idle", {30'd0, cmd_ready2, prdy2}, 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
